// File: rtl/bcd_7seg_scan_driver.sv
// Multiplexed 7-segment driver: scans DIGITS common-anode digits and swaps in
// newly loaded data only at frame boundaries.
module bcd_7seg_scan_driver #(
  parameter int DIGITS = 4,
  parameter int DIV    = 50000,
  parameter bit HEX_EN = 1'b0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [4*DIGITS-1:0] bcd_data,
  input  logic [DIGITS-1:0]   dp_in,
  input  logic                load,
  input  logic                lzb_en,
  input  logic                blank,
  output logic [6:0]          seg,
  output logic                dp,
  output logic [DIGITS-1:0]   an,
  output logic                pending,
  output logic                frame_done
);

  localparam int PW = $clog2(DIV);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [PW-1:0]       presc_q, presc_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [4*DIGITS-1:0] disp_q, disp_d;
  logic [DIGITS-1:0]   disp_dp_q, disp_dp_d;
  logic [4*DIGITS-1:0] buf_q, buf_d;
  logic [DIGITS-1:0]   buf_dp_q, buf_dp_d;
  logic                pend_q, pend_d;
  logic [6:0]          seg_q, seg_d;
  logic                dp_q, dp_d;
  logic [DIGITS-1:0]   an_q, an_d;

  logic                slot_wrap;
  logic                frame_wrap;
  logic [DIGITS-1:0]   lz;
  logic [3:0]          cur_dig;
  logic                cur_dp;
  logic                cur_lz;

  function automatic logic [6:0] decode(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0:    s = 7'h40;
      4'h1:    s = 7'h79;
      4'h2:    s = 7'h24;
      4'h3:    s = 7'h30;
      4'h4:    s = 7'h19;
      4'h5:    s = 7'h12;
      4'h6:    s = 7'h02;
      4'h7:    s = 7'h78;
      4'h8:    s = 7'h00;
      4'h9:    s = 7'h10;
      4'hA:    s = HEX_EN ? 7'h08 : 7'h3F;
      4'hB:    s = HEX_EN ? 7'h03 : 7'h3F;
      4'hC:    s = HEX_EN ? 7'h46 : 7'h3F;
      4'hD:    s = HEX_EN ? 7'h21 : 7'h3F;
      4'hE:    s = HEX_EN ? 7'h06 : 7'h3F;
      default: s = HEX_EN ? 7'h0E : 7'h3F;
    endcase
    return s;
  endfunction

  assign slot_wrap  = (presc_q == PW'(DIV - 1));
  assign frame_wrap = slot_wrap && (idx_q == IW'(DIGITS - 1));

  always_comb begin
    presc_d   = slot_wrap ? '0 : presc_q + PW'(1);
    idx_d     = idx_q;
    if (slot_wrap) idx_d = frame_wrap ? '0 : idx_q + IW'(1);

    disp_d    = disp_q;
    disp_dp_d = disp_dp_q;
    buf_d     = buf_q;
    buf_dp_d  = buf_dp_q;
    pend_d    = pend_q;
    // Swap uses the buffer as it stood before this cycle's load, so a load on
    // the wrap cycle is held over to the next frame.
    if (frame_wrap && pend_q) begin
      disp_d    = buf_q;
      disp_dp_d = buf_dp_q;
      pend_d    = 1'b0;
    end
    if (load) begin
      buf_d    = bcd_data;
      buf_dp_d = dp_in;
      pend_d   = 1'b1;
    end
  end

  // lz[i]: digit i and every digit above it are zero.
  always_comb begin
    lz = '0;
    lz[DIGITS-1] = (disp_q[4*DIGITS-1 -: 4] == 4'h0);
    for (int i = DIGITS - 2; i >= 0; i--) begin
      lz[i] = lz[i+1] && (disp_q[4*i +: 4] == 4'h0);
    end
  end

  always_comb begin
    cur_dig = '0;
    cur_dp  = 1'b0;
    cur_lz  = 1'b0;
    an_d    = '1;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IW'(i)) begin
        cur_dig  = disp_q[4*i +: 4];
        cur_dp   = disp_dp_q[i];
        cur_lz   = lz[i];
        an_d[i]  = 1'b0;
      end
    end
    seg_d = decode(cur_dig);
    if (lzb_en && (idx_q != '0) && cur_lz) seg_d = 7'h7F;
    dp_d = ~cur_dp;
    if (blank) begin
      an_d  = '1;
      seg_d = 7'h7F;
      dp_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q   <= '0;
      idx_q     <= '0;
      disp_q    <= '0;
      disp_dp_q <= '0;
      buf_q     <= '0;
      buf_dp_q  <= '0;
      pend_q    <= 1'b0;
      seg_q     <= 7'h7F;
      dp_q      <= 1'b1;
      an_q      <= '1;
    end else begin
      presc_q   <= presc_d;
      idx_q     <= idx_d;
      disp_q    <= disp_d;
      disp_dp_q <= disp_dp_d;
      buf_q     <= buf_d;
      buf_dp_q  <= buf_dp_d;
      pend_q    <= pend_d;
      seg_q     <= seg_d;
      dp_q      <= dp_d;
      an_q      <= an_d;
    end
  end

  assign seg        = seg_q;
  assign dp         = dp_q;
  assign an         = an_q;
  assign pending    = pend_q & ~reset;
  assign frame_done = frame_wrap & ~reset;

endmodule

// File: tb/tb_bcd_7seg_scan_driver.sv
// Directed bench for bcd_7seg_scan_driver (DIGITS=4, DIV=4); two instances
// share stimulus and differ only in HEX_EN.
module tb_bcd_7seg_scan_driver;

  logic        clk = 1'b0;
  logic        reset, load, lzb_en, blank;
  logic [15:0] bcd_data;
  logic [3:0]  dp_in;
  logic [6:0]  seg0, seg1;
  logic        dp0, dp1, pend0, pend1, fd0, fd1;
  logic [3:0]  an0, an1;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  bcd_7seg_scan_driver #(.DIGITS(4), .DIV(4), .HEX_EN(1'b0)) dut0 (
    .clk(clk), .reset(reset), .bcd_data(bcd_data), .dp_in(dp_in), .load(load),
    .lzb_en(lzb_en), .blank(blank), .seg(seg0), .dp(dp0), .an(an0),
    .pending(pend0), .frame_done(fd0)
  );

  bcd_7seg_scan_driver #(.DIGITS(4), .DIV(4), .HEX_EN(1'b1)) dut1 (
    .clk(clk), .reset(reset), .bcd_data(bcd_data), .dp_in(dp_in), .load(load),
    .lzb_en(lzb_en), .blank(blank), .seg(seg1), .dp(dp1), .an(an1),
    .pending(pend1), .frame_done(fd1)
  );

  typedef struct {
    logic [15:0] data;
    logic [3:0]  dpv;
    logic        lzb;
    logic [27:0] e0;   // expected seg {d3,d2,d1,d0}, HEX_EN=0
    logic [27:0] e1;   // expected seg {d3,d2,d1,d0}, HEX_EN=1
  } vec_t;

  vec_t tv[7];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] get7(input logic [27:0] p, input int d);
    return p[7*d +: 7];
  endfunction

  function automatic int an_digit(input logic [3:0] a);
    int r;
    r = -1;
    for (int k = 0; k < 4; k++) if (a == ~(4'b0001 << k)) r = k;
    return r;
  endfunction

  task automatic wait_fd();
    int n;
    n = 0;
    while (!fd0 && n < 40) begin
      tick();
      n++;
    end
    chk("fd_wait", {31'b0, fd0}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [27:0] prev_e0;
    logic        prev_lzb;
    logic        hold;
    logic [3:0]  exp_an;
    int          d, n, cnt;

    tv[0] = '{16'h1234, 4'b0000, 1'b0, {7'h79, 7'h24, 7'h30, 7'h19}, {7'h79, 7'h24, 7'h30, 7'h19}};
    tv[1] = '{16'h5678, 4'b0101, 1'b0, {7'h12, 7'h02, 7'h78, 7'h00}, {7'h12, 7'h02, 7'h78, 7'h00}};
    tv[2] = '{16'h90AF, 4'b0010, 1'b0, {7'h10, 7'h40, 7'h3F, 7'h3F}, {7'h10, 7'h40, 7'h08, 7'h0E}};
    tv[3] = '{16'h0050, 4'b1000, 1'b1, {7'h7F, 7'h7F, 7'h12, 7'h40}, {7'h7F, 7'h7F, 7'h12, 7'h40}};
    tv[4] = '{16'h0000, 4'b0001, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h40}, {7'h7F, 7'h7F, 7'h7F, 7'h40}};
    tv[5] = '{16'hB0C1, 4'b0000, 1'b1, {7'h3F, 7'h40, 7'h3F, 7'h79}, {7'h03, 7'h40, 7'h46, 7'h79}};
    tv[6] = '{16'h0007, 4'b0000, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h78}, {7'h7F, 7'h7F, 7'h7F, 7'h78}};

    reset = 1'b1; load = 1'b0; lzb_en = 1'b0; blank = 1'b0;
    bcd_data = '0; dp_in = '0;

    // reset state, during and on the cycle after reset
    tick();
    chk("reset_during", {an0, seg0, dp0, fd0, pend0, seg1}, {4'hF, 7'h7F, 1'b1, 1'b0, 1'b0, 7'h7F});
    tick();
    reset = 1'b0;
    chk("reset_after", {an0, seg0, dp0, fd0, pend0}, {4'hF, 7'h7F, 1'b1, 1'b0, 1'b0});

    prev_e0  = {4{7'h40}};
    prev_lzb = 1'b0;

    for (int i = 0; i < 7; i++) begin
      lzb_en = tv[i].lzb;
      hold   = !tv[i].lzb && !prev_lzb;
      tick();
      tick();
      bcd_data = tv[i].data;
      dp_in    = tv[i].dpv;
      load     = 1'b1;
      tick();
      load     = 1'b0;
      chk("pending_set", {31'b0, pend0}, 32'd1);
      n = 0;
      while (!fd0 && n < 40) begin
        d = an_digit(an0);
        if (hold && d >= 0) chk("hold_old", {25'b0, seg0}, {25'b0, get7(prev_e0, d)});
        tick();
        n++;
      end
      chk("fd_wait", {31'b0, fd0}, 32'd1);
      tick();
      d = an_digit(an0);
      if (hold && d >= 0) chk("hold_old", {25'b0, seg0}, {25'b0, get7(prev_e0, d)});
      chk("pending_clr", {31'b0, pend0}, 32'd0);
      tick();
      for (int k = 0; k < 16; k++) begin
        exp_an = ~(4'b0001 << (k / 4));
        chk($sformatf("frame_v%0d_s%0d", i, k), {an0, seg0, seg1, dp0, dp1},
            {exp_an, get7(tv[i].e0, k / 4), get7(tv[i].e1, k / 4),
             ~tv[i].dpv[k / 4], ~tv[i].dpv[k / 4]});
        if (k < 15) tick();
      end
      tick();
      prev_e0  = tv[i].e0;
      prev_lzb = tv[i].lzb;
    end

    // load coinciding with the frame wrap
    lzb_en = 1'b0;
    tick();
    bcd_data = 16'h1234; dp_in = '0; load = 1'b1;
    tick();
    load = 1'b0;
    wait_fd();
    bcd_data = 16'h4321; load = 1'b1;
    tick();
    load = 1'b0;
    chk("coinc_pending", {31'b0, pend0}, 32'd1);
    tick();
    chk("coinc_old_shown", {an0, seg0}, {4'b1110, 7'h19});
    wait_fd();
    tick();
    chk("coinc_pending_clr", {31'b0, pend0}, 32'd0);
    tick();
    chk("coinc_new_shown", {an0, seg0}, {4'b1110, 7'h79});

    // reset mid-frame discards a pending load
    tick();
    bcd_data = 16'h5678; load = 1'b1;
    tick();
    load = 1'b0;
    chk("rst_pending_pre", {31'b0, pend0}, 32'd1);
    reset = 1'b1;
    tick();
    chk("rst_mid", {an0, seg0, dp0, fd0, pend0}, {4'hF, 7'h7F, 1'b1, 1'b0, 1'b0});
    reset = 1'b0;
    cnt = 0;
    tick();
    cnt++;
    chk("rst_restart", {an0, seg0, dp0}, {4'b1110, 7'h40, 1'b1});
    while (!fd0 && cnt < 40) begin
      tick();
      cnt++;
    end
    chk("rst_first_fd", cnt, 32'd15);
    tick();
    tick();
    chk("rst_discard", {an0, seg0, pend0}, {4'b1110, 7'h40, 1'b0});

    // blank: outputs dark, scanning and load handling continue
    blank = 1'b1;
    tick();
    chk("blank_out", {an0, seg0, dp0, an1, seg1}, {4'hF, 7'h7F, 1'b1, 4'hF, 7'h7F});
    wait_fd();
    cnt = 0;
    do begin
      tick();
      cnt++;
      if (an0 !== 4'hF) chk("blank_an", {28'b0, an0}, 32'hF);
    end while (!fd0 && cnt < 40);
    chk("blank_fd_period", cnt, 32'd16);
    tick();
    bcd_data = 16'h0009; load = 1'b1;
    tick();
    load = 1'b0;
    chk("blank_load_pending", {31'b0, pend0}, 32'd1);
    wait_fd();
    blank = 1'b0;
    tick();
    chk("blank_swap", {31'b0, pend0}, 32'd0);
    tick();
    chk("unblank_show", {an0, seg0, dp0}, {4'b1110, 7'h10, 1'b1});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
